ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Execute-stage datapath block for the pipelined CPU. It takes decoded operands plus the 4-bit ALU control code produced by the ALU controller and computes the ALU result and zero flag. The result is registered into a 2-entry elastic EX/MEM buffer (main + skid) with valid/ready handshakes on both sides. It sits directly downstream of the ALU controller and upstream of the memory stage.

## Interface

- WIDTH, 32, operand/result width in bits (≥ 2)

- clk  input  1  rising-edge clock (single clock domain)
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush (branch/exception squash)
- in_valid  input  1  upstream entry present
- in_ready  output  1  block can accept an entry this cycle
- in_alu_ctl  input  4  ALU control code
- in_a  input  WIDTH  operand A (rs)
- in_b  input  WIDTH  operand B (rt or sign-extended immediate)
- in_rd  input  5  destination register index
- in_reg_write  input  1  writeback enable
- out_valid  output  1  EX/MEM entry present
- out_ready  input  1  downstream consumes entry this cycle
- out_result  output  WIDTH  ALU result
- out_zero  output  1  result == 0
- out_rd  output  5  registered in_rd
- out_reg_write  output  1  registered in_reg_write, forced 0 when illegal
- out_illegal  output  1  in_alu_ctl was not a supported code

## Operation

- ALU codes: 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH, no overflow trap); 0110 SUB (a − b mod 2^WIDTH); 0111 SLT (signed a < b → 1, else 0, zero-extended).
- Any other code: result 0, out_zero 1, out_illegal 1, out_reg_write 0.
- Result is computed combinationally from the in_* signals and captured together with rd/reg_write/illegal/zero at the accept edge. Outputs come only from registers.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready. in_* signals are ignored when push = 0. The out_* payload holds stable while out_valid = 1 and out_ready = 0.
- Storage: main (drives out_*), skid (overflow). Entries leave in strict arrival order.
- Per edge, when flush = 0:
  - main empty, or pop: main ← skid if skid full (skid then ← push data if push, else empty), else main ← push data (main becomes empty if no push).
  - main full and no pop: push data → skid.
- in_ready is registered and equals !skid_full. It never depends combinationally on out_ready.
- Occupancy 0..2. Simultaneous push and pop at occupancy 2 is impossible because in_ready = 0.
- Flush (synchronous, priority over everything): both entries are invalidated at the edge. Any push in the same cycle is dropped. Next cycle: out_valid 0, in_ready 1.

## Timing

- Reset (async, rst_n low): out_valid 0, in_ready 1, out_result 0, out_zero 0, out_rd 0, out_reg_write 0, out_illegal 0, skid empty. Takes effect immediately, mid-transfer included.
- Latency: an entry accepted at edge k is on out_* after edge k if main was empty or popped at edge k. Otherwise it appears one edge after the preceding entry pops.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- Backpressure: with out_ready held 0 and in_valid held 1 from empty, two entries are accepted (edges k, k+1). in_ready falls after edge k+1.
- After out_ready returns to 1, in_ready rises one cycle after the pop that empties the skid.

## Test plan

- Reset mid-stream: rst_n low with out_valid=1 → all outputs at reset values immediately, in_ready=1; first entry after release appears 1 edge after acceptance.
- Op coverage, out_ready=1:
  - ADD 0xFFFFFFFF+1 → 0, zero=1.
  - SUB 5−7 → 0xFFFFFFFE.
  - AND 0xF0F0&0xFF00 → 0xF000.
  - OR 0x0F|0xF0 → 0xFF.
  - SLT −1<1 → 1; SLT 1<−1 → 0.
- Illegal code 1111, reg_write=1 → out_illegal=1, result 0, zero=1, out_reg_write=0.
- Backpressure: out_ready=0, push A,B,C on consecutive cycles → A,B accepted, in_ready=0, C held off; out_ready=1 → A,B,C emerge in order, none lost or duplicated.
- Flush with occupancy 2 and in_valid=1 → next cycle out_valid=0, in_ready=1; flushed and same-cycle inputs never appear.
- Random: random in_valid/out_ready/flush over 10k cycles against a reference queue model → exact ordered match; out_* stable while stalled.

Source files
------------

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - EX-stage ALU with 2-entry elastic EX/MEM buffer (main + skid)
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_illegal
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  // Combinational ALU result for the incoming entry
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             alu_slt;

  assign alu_slt = ($signed(in_a) < $signed(in_b));

  // Decode the control code and evaluate the selected operation
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (in_alu_ctl)
      CTL_AND: alu_result = in_a & in_b;
      CTL_OR:  alu_result = in_a | in_b;
      CTL_ADD: alu_result = in_a + in_b;
      CTL_SUB: alu_result = in_a - in_b;
      CTL_SLT: alu_result = {{(WIDTH-1){1'b0}}, alu_slt};
      default: begin
        alu_result  = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // Entry payload as it will be stored; illegal ops never write back
  logic [WIDTH-1:0] new_result;
  logic             new_zero;
  logic [4:0]       new_rd;
  logic             new_reg_write;
  logic             new_illegal;

  // Assemble the payload captured at the accept edge
  always_comb begin
    new_result    = alu_result;
    new_zero      = (alu_result == '0);
    new_rd        = in_rd;
    new_reg_write = in_reg_write & ~alu_illegal;
    new_illegal   = alu_illegal;
  end

  // Buffer state: main drives out_*, skid absorbs one entry of backpressure
  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic             skid_zero;
  logic [4:0]       skid_rd;
  logic             skid_reg_write;
  logic             skid_illegal;

  logic push;
  logic pop;
  logic main_load;

  // in_ready comes straight from the skid flop, so it is registered and
  // independent of out_ready
  assign in_ready  = ~skid_valid;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign main_load = ~out_valid | pop;

  // Main register: refilled from skid first to keep arrival order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        out_valid     <= 1'b1;
        out_result    <= skid_result;
        out_zero      <= skid_zero;
        out_rd        <= skid_rd;
        out_reg_write <= skid_reg_write;
        out_illegal   <= skid_illegal;
      end else begin
        out_valid <= push;
        if (push) begin
          out_result    <= new_result;
          out_zero      <= new_zero;
          out_rd        <= new_rd;
          out_reg_write <= new_reg_write;
          out_illegal   <= new_illegal;
        end
      end
    end
  end

  // Skid register: takes a push whenever main cannot, or refills behind a
  // skid-to-main transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid     <= 1'b0;
      skid_result    <= '0;
      skid_zero      <= 1'b0;
      skid_rd        <= '0;
      skid_reg_write <= 1'b0;
      skid_illegal   <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else begin
      if (main_load) begin
        if (skid_valid) begin
          skid_valid <= push;
        end
      end else if (push) begin
        skid_valid <= 1'b1;
      end
      if (push && !(main_load && !skid_valid)) begin
        skid_result    <= new_result;
        skid_zero      <= new_zero;
        skid_rd        <= new_rd;
        skid_reg_write <= new_reg_write;
        skid_illegal   <= new_illegal;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_ctl;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  ex_alu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctl(in_alu_ctl), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } ent_t;

  ent_t        q[$];
  logic [31:0] obs[$];
  int          ntotal = 0;
  int          npass  = 0;

  // Reference: the ALU rules written as plain arithmetic
  function automatic ent_t ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd,
                                   input logic rw);
    ent_t e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.rd  = rd;
    e.ill = 1'b0;
    case (ctl)
      4'd0: e.result = a & b;
      4'd1: e.result = a | b;
      4'd2: e.result = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd6: e.result = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd7: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: begin e.result = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.result == 32'd0);
    e.rw   = e.ill ? 1'b0 : rw;
    return e;
  endfunction

  function automatic ent_t dut_ent();
    return {out_result, out_zero, out_rd, out_reg_write, out_illegal};
  endfunction

  // One cycle: drive at negedge, advance occupancy model at posedge
  task automatic tick(input logic v, input logic [3:0] ctl, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic rw,
                      input logic ordy, input logic fl);
    bit p, pp;
    in_valid = v; in_alu_ctl = ctl; in_a = a; in_b = b;
    in_rd = rd; in_reg_write = rw; out_ready = ordy; flush = fl;
    p  = v && (q.size() < 2);
    pp = ordy && (q.size() > 0);
    if (pp && !fl) obs.push_back(q[0].result);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (p)  q.push_back(ref_alu(ctl, a, b, rd, rw));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_ctl = 4'd0; in_a = 0; in_b = 0; in_rd = 0; in_reg_write = 0;
    @(posedge clk); @(negedge clk);
    ntotal++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else npass++;
    ntotal++; if (dut_ent() !== '0) $display("FAIL reset_payload got %h exp 0", dut_ent()); else npass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    tick(1'b1, 4'd2, 32'd10, 32'd20, 5'd3, 1'b1, 1'b0, 1'b0);
    ntotal++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", out_valid); else npass++;
    #1 rst_n = 1'b0;
    #1;
    ntotal++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL mid_reset_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else npass++;
    ntotal++; if (dut_ent() !== '0) $display("FAIL mid_reset_payload got %h exp 0", dut_ent()); else npass++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 4'd2, 32'd2, 32'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    ntotal++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_rd !== 5'd7) $display("FAIL mid_first_entry got v=%b res=%h rd=%0d exp v=1 res=5 rd=7", out_valid, out_result, out_rd); else npass++;
    idle(1'b1);
  endtask

  task automatic test_ops();
    logic [3:0]  ctls[6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd7};
    logic [31:0] as[6]   = '{32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0, 32'h0F, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] bs[6]   = '{32'd1, 32'd7, 32'h0000_FF00, 32'hF0, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] exp_r[6] = '{32'd0, 32'hFFFF_FFFE, 32'h0000_F000, 32'hFF, 32'd1, 32'd0};
    logic        exp_z[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, ctls[i], as[i], bs[i], 5'(i + 1), 1'b1, 1'b1, 1'b0);
      ntotal++;
      if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_zero !== exp_z[i] || out_reg_write !== 1'b1 || out_illegal !== 1'b0)
        $display("FAIL op_%0d got v=%b res=%h z=%b rw=%b ill=%b exp v=1 res=%h z=%b rw=1 ill=0",
                 i, out_valid, out_result, out_zero, out_reg_write, out_illegal, exp_r[i], exp_z[i]);
      else npass++;
    end
    idle(1'b1);
  endtask

  task automatic test_illegal();
    tick(1'b1, 4'hF, 32'h1234, 32'h5678, 5'd9, 1'b1, 1'b1, 1'b0);
    ntotal++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 || out_reg_write !== 1'b0)
      $display("FAIL illegal got v=%b ill=%b res=%h z=%b rw=%b exp v=1 ill=1 res=0 z=1 rw=0",
               out_valid, out_illegal, out_result, out_zero, out_reg_write);
    else npass++;
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq[3] = '{32'd2, 32'd12, 32'd6};
    obs.delete();
    tick(1'b1, 4'd2, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    ntotal++; if (in_ready !== 1'b1 || out_result !== 32'd2) $display("FAIL bp_a got r=%b res=%h exp r=1 res=2", in_ready, out_result); else npass++;
    tick(1'b1, 4'd1, 32'd4, 32'd8, 5'd2, 1'b1, 1'b0, 1'b0);
    ntotal++; if (in_ready !== 1'b0 || out_result !== 32'd2) $display("FAIL bp_b got r=%b res=%h exp r=0 res=2", in_ready, out_result); else npass++;
    tick(1'b1, 4'd6, 32'd9, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    ntotal++; if (in_ready !== 1'b0 || out_result !== 32'd2) $display("FAIL bp_c_held got r=%b res=%h exp r=0 res=2", in_ready, out_result); else npass++;
    tick(1'b1, 4'd6, 32'd9, 32'd3, 5'd3, 1'b1, 1'b1, 1'b0);
    ntotal++; if (in_ready !== 1'b1 || out_result !== 32'd12) $display("FAIL bp_release got r=%b res=%h exp r=1 res=c", in_ready, out_result); else npass++;
    tick(1'b1, 4'd6, 32'd9, 32'd3, 5'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    ntotal++; if (out_valid !== 1'b0) $display("FAIL bp_drained got v=%b exp 0", out_valid); else npass++;
    ntotal++; if (obs.size() != 3) $display("FAIL bp_count got %0d exp 3", obs.size()); else npass++;
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      ntotal++; if (obs[i] !== exp_seq[i]) $display("FAIL bp_order_%0d got %h exp %h", i, obs[i], exp_seq[i]); else npass++;
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 4'd2, 32'd100, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 4'd2, 32'd200, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    ntotal++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL flush_full got v=%b r=%b exp v=1 r=0", out_valid, in_ready); else npass++;
    tick(1'b1, 4'd2, 32'd300, 32'd1, 5'd6, 1'b1, 1'b0, 1'b1);
    ntotal++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_next got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else npass++;
    idle(1'b1);
    idle(1'b1);
    ntotal++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got v=%b exp 0", out_valid); else npass++;
  endtask

  task automatic test_random();
    logic [3:0] legal[5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
    ent_t prev;
    bit   stalled;
    int   errs;
    logic [3:0] ctl;
    logic v, o, f;
    errs = 0;
    stalled = 1'b0;
    prev = '0;
    for (int c = 0; c < 10000; c++) begin
      ntotal++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        if (errs < 10) $display("FAIL rand_hs cyc %0d got v=%b r=%b exp v=%b r=%b", c, out_valid, in_ready, q.size() > 0, q.size() < 2);
        errs++;
      end else npass++;
      if (q.size() > 0) begin
        ntotal++;
        if (dut_ent() !== q[0]) begin
          if (errs < 10) $display("FAIL rand_payload cyc %0d got %h exp %h", c, dut_ent(), q[0]);
          errs++;
        end else npass++;
      end
      if (stalled) begin
        ntotal++;
        if (dut_ent() !== prev) begin
          if (errs < 10) $display("FAIL rand_stable cyc %0d got %h exp %h", c, dut_ent(), prev);
          errs++;
        end else npass++;
      end
      ctl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 4)];
      v = ($urandom_range(0, 99) < 65);
      o = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 63) == 0);
      stalled = out_valid && !o && !f;
      prev = dut_ent();
      tick(v, ctl, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           5'($urandom), 1'($urandom), o, f);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_ops();
    test_illegal();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
